// File: rtl/gb_psum_pool_seq.sv
// rtl/gb_psum_pool_seq.sv - psum bank row readout sequencer feeding the pooling unit
// Streams rows base..base+last from the global buffer into a single skid-free output register.
module gb_psum_pool_seq #(
  parameter int ADDR_WIDTH = 8,
  parameter int PSUM_WIDTH = 32,
  parameter int NUM_PEB    = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg_val,
  output logic                             cfg_rdy,
  input  logic [ADDR_WIDTH-1:0]            cfg_base,
  input  logic [ADDR_WIDTH-1:0]            cfg_last,
  input  logic                             start,
  input  logic                             abort,
  output logic                             busy,
  output logic                             done,
  output logic                             POOLGB_rdy,
  output logic [ADDR_WIDTH-1:0]            POOLGB_addr,
  output logic                             POOLGB_fnh,
  input  logic                             GBPOOL_val,
  input  logic [PSUM_WIDTH*NUM_PEB-1:0]    GBPOOL_data,
  output logic                             SEQPOOL_val,
  output logic [PSUM_WIDTH*NUM_PEB-1:0]    SEQPOOL_data,
  output logic [ADDR_WIDTH-1:0]            SEQPOOL_addr,
  input  logic                             POOLSEQ_rdy
);

  localparam int DW = PSUM_WIDTH * NUM_PEB;
  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_FNH   = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  sval_q, sval_d;
  logic [DW-1:0]         sdata_q, sdata_d;
  logic [ADDR_WIDTH-1:0] saddr_q, saddr_d;

  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  pool_rdy;
  logic                  accept;
  logic                  consume;

  // cnt is one bit wider than the address so a full 2^ADDR_WIDTH-row pass never aliases to 0
  assign rd_addr  = base_q + cnt_q[ADDR_WIDTH-1:0];
  assign pool_rdy = (state_q == S_RUN) && (!sval_q || POOLSEQ_rdy);
  assign accept   = GBPOOL_val && pool_rdy;
  assign consume  = sval_q && POOLSEQ_rdy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    last_d  = last_q;
    sval_d  = sval_q;
    sdata_d = sdata_q;
    saddr_d = saddr_q;

    if (cfg_val && (state_q == S_IDLE)) begin
      base_d = cfg_base;
      last_d = cfg_last;
    end

    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sval_d  = 1'b0;
    end else begin
      if (consume) sval_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (accept) begin
            sdata_d = GBPOOL_data;
            saddr_d = rd_addr;
            sval_d  = 1'b1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == {1'b0, last_q}) state_d = S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!sval_q || POOLSEQ_rdy) state_d = S_FNH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      last_q  <= '0;
      sval_q  <= 1'b0;
      sdata_q <= '0;
      saddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      last_q  <= last_d;
      sval_q  <= sval_d;
      sdata_q <= sdata_d;
      saddr_q <= saddr_d;
    end
  end

  // abort wins over the finish pulse even in the FNH cycle itself
  assign POOLGB_fnh   = (state_q == S_FNH) && !abort;
  assign done         = (state_q == S_FNH) && !abort;
  assign cfg_rdy      = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign POOLGB_rdy   = pool_rdy;
  assign POOLGB_addr  = rd_addr;
  assign SEQPOOL_val  = sval_q;
  assign SEQPOOL_data = sdata_q;
  assign SEQPOOL_addr = saddr_q;

endmodule

// File: tb/tb_gb_psum_pool_seq.sv
// tb/tb_gb_psum_pool_seq.sv - directed table-driven bench for gb_psum_pool_seq
module tb_gb_psum_pool_seq;

  logic         clk;
  logic         rst_n;
  logic         cfg_val;
  logic         cfg_rdy;
  logic [7:0]   cfg_base;
  logic [7:0]   cfg_last;
  logic         start;
  logic         abort;
  logic         busy;
  logic         done;
  logic         POOLGB_rdy;
  logic [7:0]   POOLGB_addr;
  logic         POOLGB_fnh;
  logic         GBPOOL_val;
  logic [511:0] GBPOOL_data;
  logic         SEQPOOL_val;
  logic [511:0] SEQPOOL_data;
  logic [7:0]   SEQPOOL_addr;
  logic         POOLSEQ_rdy;

  int checks = 0;
  int errors = 0;

  gb_psum_pool_seq dut (
    .clk(clk), .rst_n(rst_n), .cfg_val(cfg_val), .cfg_rdy(cfg_rdy),
    .cfg_base(cfg_base), .cfg_last(cfg_last), .start(start), .abort(abort),
    .busy(busy), .done(done), .POOLGB_rdy(POOLGB_rdy), .POOLGB_addr(POOLGB_addr),
    .POOLGB_fnh(POOLGB_fnh), .GBPOOL_val(GBPOOL_val), .GBPOOL_data(GBPOOL_data),
    .SEQPOOL_val(SEQPOOL_val), .SEQPOOL_data(SEQPOOL_data), .SEQPOOL_addr(SEQPOOL_addr),
    .POOLSEQ_rdy(POOLSEQ_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    logic [7:0] last;
    int         stall;
    logic       with_start;
    int         rows;
    logic [7:0] last_addr;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [511:0] pat(input logic [7:0] a);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = {a, 8'(i), ~a, 8'h5A};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_rows(input logic [7:0] base, input int stall, input int rows,
                          input logic [7:0] last_addr);
    int acc = 0;
    int cons = 0;
    int fnh_n = 0;
    int done_n = 0;
    int stall_left = stall;
    logic prev_acc = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] cons_addr = 8'h00;
    bit fin = 1'b0;
    for (int cyc = 0; cyc < 700 && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      cfg_val = 1'b0;
      GBPOOL_val = 1'b1;
      GBPOOL_data = pat(POOLGB_addr);
      POOLSEQ_rdy = !(stall_left > 0 && cons == 0 && SEQPOOL_val);
      if (!POOLSEQ_rdy) stall_left--;
      #1;
      if (prev_acc) begin
        chk("latency_val", 64'(SEQPOOL_val), 64'd1);
        chk("latency_addr", 64'(SEQPOOL_addr), 64'(prev_addr));
      end
      if (stall == 0 && acc < rows) chk("rdy_stream", 64'(POOLGB_rdy), 64'd1);
      prev_acc = POOLGB_rdy;
      prev_addr = POOLGB_addr;
      if (POOLGB_rdy) begin
        chk("rd_addr", 64'(POOLGB_addr), 64'(8'(base + acc)));
        acc++;
      end
      if (SEQPOOL_val && !POOLSEQ_rdy) begin
        chk("stall_rdy", 64'(POOLGB_rdy), 64'd0);
        chk("stall_data", 64'(SEQPOOL_data == pat(base)), 64'd1);
      end
      if (SEQPOOL_val && POOLSEQ_rdy) begin
        chk("out_addr", 64'(SEQPOOL_addr), 64'(8'(base + cons)));
        chk("out_data", 64'(SEQPOOL_data == pat(8'(base + cons))), 64'd1);
        cons_addr = SEQPOOL_addr;
        cons++;
      end
      if (done) done_n++;
      if (POOLGB_fnh) begin
        fnh_n++;
        chk("fnh_after_drain", 64'(cons), 64'(rows));
        fin = 1'b1;
      end
    end
    chk("rows_accepted", 64'(acc), 64'(rows));
    chk("rows_consumed", 64'(cons), 64'(rows));
    chk("last_out_addr", 64'(cons_addr), 64'(last_addr));
    chk("fnh_pulses", 64'(fnh_n), 64'd1);
    chk("done_pulses", 64'(done_n), 64'd1);
    @(negedge clk);
    GBPOOL_val = 1'b0;
    #1;
    chk("busy_after", 64'(busy), 64'd0);
    chk("fnh_after", 64'(POOLGB_fnh), 64'd0);
    chk("cfg_rdy_after", 64'(cfg_rdy), 64'd1);
  endtask

  initial begin
    vecs[0] = '{8'h10, 8'h03, 0, 1'b0, 4,   8'h13};
    vecs[1] = '{8'hFE, 8'h03, 0, 1'b1, 4,   8'h01};
    vecs[2] = '{8'h20, 8'h03, 5, 1'b0, 4,   8'h23};
    vecs[3] = '{8'h40, 8'h00, 0, 1'b1, 1,   8'h40};
    vecs[4] = '{8'h05, 8'hFF, 0, 1'b0, 256, 8'h04};

    rst_n = 1'b0; cfg_val = 1'b0; cfg_base = 8'h00; cfg_last = 8'h00;
    start = 1'b0; abort = 1'b0; GBPOOL_val = 1'b0; GBPOOL_data = '0; POOLSEQ_rdy = 1'b1;
    #1;
    chk("rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sval", 64'(SEQPOOL_val), 64'd0);
    chk("rst_saddr", 64'(SEQPOOL_addr), 64'd0);
    chk("rst_sdata", 64'(SEQPOOL_data == 512'd0), 64'd1);
    chk("rst_fnh_done", 64'({POOLGB_fnh, done}), 64'd0);
    chk("rst_rd_addr", 64'(POOLGB_addr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      cfg_val = 1'b1; cfg_base = vecs[v].base; cfg_last = vecs[v].last;
      if (vecs[v].with_start) begin
        start = 1'b1;
      end else begin
        @(negedge clk);
        cfg_val = 1'b0;
        start = 1'b1;
      end
      run_rows(vecs[v].base, vecs[v].stall, vecs[v].rows, vecs[v].last_addr);
    end

    // abort after the second accepted row, then restart from the same base
    begin
      int acc = 0;
      @(negedge clk);
      cfg_val = 1'b1; cfg_base = 8'h30; cfg_last = 8'h07; start = 1'b1;
      for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
        @(negedge clk);
        cfg_val = 1'b0; start = 1'b0; GBPOOL_val = 1'b1; POOLSEQ_rdy = 1'b1;
        GBPOOL_data = pat(POOLGB_addr);
        #1;
        if (POOLGB_rdy) acc++;
      end
      chk("abort_pre_rows", 64'(acc), 64'd2);
      @(negedge clk);
      abort = 1'b1; start = 1'b1;
      #1;
      chk("abort_cycle_fnh", 64'({POOLGB_fnh, done}), 64'd0);
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_sval", 64'(SEQPOOL_val), 64'd0);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        #1;
        chk("abort_no_fnh", 64'({POOLGB_fnh, done}), 64'd0);
      end
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("restart_busy", 64'(busy), 64'd1);
      chk("restart_addr", 64'(POOLGB_addr), 64'h30);
      @(negedge clk);
      abort = 1'b1; GBPOOL_val = 1'b0;
      @(negedge clk);
      abort = 1'b0;
    end

    // cfg and start while busy must be ignored
    @(negedge clk);
    cfg_val = 1'b1; cfg_base = 8'h50; cfg_last = 8'h03; start = 1'b1;
    @(negedge clk);
    cfg_val = 1'b1; cfg_base = 8'h99; cfg_last = 8'h11; start = 1'b1; GBPOOL_val = 1'b0;
    #1;
    chk("busy_cfg_rdy", 64'(cfg_rdy), 64'd0);
    run_rows(8'h50, 0, 4, 8'h53);
    @(negedge clk);
    start = 1'b1;
    run_rows(8'h50, 0, 4, 8'h53);

    // reset in the middle of a readout
    @(negedge clk);
    cfg_val = 1'b1; cfg_base = 8'h60; cfg_last = 8'h07; start = 1'b1;
    @(negedge clk);
    cfg_val = 1'b0; start = 1'b0; GBPOOL_val = 1'b1; POOLSEQ_rdy = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_sval", 64'(SEQPOOL_val), 64'd0);
    chk("mid_rst_cfg_rdy", 64'(cfg_rdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    GBPOOL_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_fnh", 64'({POOLGB_fnh, done, busy}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
